// File: rtl/dual_rail_value_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dual_rail_value_capture: two-phase dual-rail receiver with valid/ready    |
// | output and a toggled acknowledge. Optional partial-token watchdog is      |
// | enabled by defining DUAL_RAIL_CAPTURE_TIMEOUT_EN.                         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dual_rail_value_capture #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0][1:0]  in,
  output logic                   ack,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid,
  input  logic                   ready,
  output logic                   err,
  output logic [WIDTH-1:0]       err_bits,
  output logic                   timeout
);

  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;

  logic [NSYNC-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0][1:0]            s;
  logic [WIDTH-1:0][1:0]            ref_q, ref_d;
  logic [WIDTH-1:0]                 done, bad, rail0_delta;
  logic                             all_done, any_done, any_bad;
  logic [1:0]                       state_q, state_d;
  logic                             ack_q, ack_d;
  logic                             valid_q, valid_d;
  logic                             err_q, err_d;
  logic [WIDTH-1:0]                 data_q, data_d;
  logic [WIDTH-1:0]                 err_bits_q, err_bits_d;
  logic                             to_hit;

  assign s = sync_q[NSYNC-1];

  // A bit is complete when exactly one of its rails moved since the last token.
  always_comb begin
    done        = '0;
    bad         = '0;
    rail0_delta = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rail0_delta[i] = s[i][0] ^ ref_q[i][0];
      done[i]        = (s[i][0] ^ ref_q[i][0]) ^ (s[i][1] ^ ref_q[i][1]);
      bad[i]         = (s[i][0] ^ ref_q[i][0]) & (s[i][1] ^ ref_q[i][1]);
    end
  end

  assign all_done = &done;
  assign any_done = |done;
  assign any_bad  = |bad;

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ack_d      = ack_q;
    err_d      = err_q;
    err_bits_d = err_bits_q;
    case (state_q)
      ST_COLLECT: begin
        if (any_bad) begin
          err_d      = 1'b1;
          err_bits_d = bad;
          state_d    = ST_ERR;
        end else if (en && all_done) begin
          ref_d   = s;
          data_d  = rail0_delta;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (to_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = ST_COLLECT;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      ref_q      <= '0;
      state_q    <= ST_COLLECT;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      err_bits_q <= '0;
    end else begin
      sync_q     <= {sync_q[NSYNC-2:0], in};
      ref_q      <= ref_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      data_q     <= data_d;
      err_bits_q <= err_bits_d;
    end
  end

`ifdef DUAL_RAIL_CAPTURE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             partial;

  assign partial = (state_q == ST_COLLECT) && !any_bad && any_done && !all_done;
  assign to_hit  = partial && en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter freezes while en is low; a full token waiting on en also freezes it.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | to_hit;
    if ((state_q != ST_COLLECT) || !any_done || (all_done && en)) begin
      cnt_d = '0;
    end else if (partial && en && !to_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_hit             = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign ack      = ack_q;
  assign valid    = valid_q;
  assign data_out = data_q;
  assign err      = err_q;
  assign err_bits = err_bits_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_value_capture.sv
`default_nettype none
// Bench for dual_rail_value_capture: directed and randomized tokens checked
// against a sender-side model of values, latency and acknowledge parity.
module tb_dual_rail_value_capture;

  localparam int W  = 4;
  localparam int SS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             ready;
  logic [W-1:0][1:0] link;
  logic             ack, valid, err, timeout;
  logic [W-1:0]     data_out, err_bits;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_ack;

  always #5 clk = ~clk;

  dual_rail_value_capture #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(link),
    .ack(ack),
    .data_out(data_out),
    .valid(valid),
    .ready(ready),
    .err(err),
    .err_bits(err_bits),
    .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sender: value 1 toggles rail 0, value 0 toggles rail 1.
  task automatic toggle(input logic [W-1:0] mask, input logic [W-1:0] val);
    for (int i = 0; i < W; i++) begin
      if (mask[i]) begin
        if (val[i]) link[i][0] = ~link[i][0];
        else        link[i][1] = ~link[i][1];
      end
    end
  endtask

  // Called right after the last toggle was driven; en high, FSM collecting.
  task automatic expect_token(input string tag, input logic [W-1:0] val);
    step(SS);
    check({tag, "_early"}, valid, 1'b0);
    step(1);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_data"}, data_out, val);
    check({tag, "_ack"}, ack, m_ack);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    m_ack = ~m_ack;
    check({tag, "_acc_valid"}, valid, 1'b0);
    check({tag, "_acc_ack"}, ack, m_ack);
  endtask

  task automatic do_reset(input string tag);
    rst  = 1'b1;
    link = '0;
    step(2);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_ack"}, ack, 1'b0);
    check({tag, "_data"}, data_out, 4'h0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_errbits"}, err_bits, 4'h0);
    check({tag, "_timeout"}, timeout, 1'b0);
    rst   = 1'b0;
    m_ack = 1'b0;
    step(1);
  endtask

  initial begin
    logic [W-1:0] val, m;
    int           mode, d;

    rst   = 1'b1;
    en    = 1'b1;
    ready = 1'b0;
    link  = '0;
    m_ack = 1'b0;

    do_reset("reset");

    // First token 4'b1001, consumer slow to accept.
    toggle(4'hF, 4'b1001);
    expect_token("tok1", 4'b1001);
    step(3);
    check("tok1_hold_valid", valid, 1'b1);
    check("tok1_hold_data", data_out, 4'b1001);
    accept("tok1");

    // ready held high, including while nothing is valid.
    ready = 1'b1;
    step(3);
    check("idle_ready_valid", valid, 1'b0);
    check("idle_ready_ack", ack, m_ack);
    toggle(4'hF, 4'hF);
    expect_token("tok2", 4'hF);
    step(1);
    m_ack = ~m_ack;
    check("tok2_auto_valid", valid, 1'b0);
    check("tok2_auto_ack", ack, m_ack);
    ready = 1'b0;

    // Skewed arrival: bit 3 five cycles late.
    toggle(4'b0111, 4'b0101);
    step(5);
    check("skew_partial_valid", valid, 1'b0);
    toggle(4'b1000, 4'b0101);
    expect_token("skew", 4'b0101);
    accept("skew");

    // en low holds a complete token pending; en drop in HOLD is harmless.
    en = 1'b0;
    toggle(4'hF, 4'b0110);
    step(10);
    check("en_low_valid", valid, 1'b0);
    en = 1'b1;
    step(1);
    check("en_rise_valid", valid, 1'b1);
    check("en_rise_data", data_out, 4'b0110);
    en = 1'b0;
    step(2);
    check("en_drop_hold_valid", valid, 1'b1);
    accept("en_drop");
    en = 1'b1;

    // Only bit 0 arrives: no capture, no watchdog in the default build.
    toggle(4'b0001, 4'b0000);
    step(40);
    check("partial_valid", valid, 1'b0);
    check("partial_timeout", timeout, 1'b0);
    check("partial_err", err, 1'b0);
    toggle(4'b1110, 4'b0000);
    expect_token("partial_done", 4'b0000);
    accept("partial_done");

    // Randomized tokens.
    for (int t = 0; t < 24; t++) begin
      val  = W'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        toggle(4'hF, val);
        expect_token("rnd_full", val);
      end else if (mode == 1) begin
        m = W'($urandom_range(1, 14));
        d = $urandom_range(1, 6);
        toggle(m, val);
        step(d);
        check("rnd_skew_partial", valid, 1'b0);
        toggle(~m, val);
        expect_token("rnd_skew", val);
      end else begin
        en = 1'b0;
        toggle(4'hF, val);
        step($urandom_range(3, 8));
        check("rnd_en_low", valid, 1'b0);
        en = 1'b1;
        step(1);
        check("rnd_en_valid", valid, 1'b1);
        check("rnd_en_data", data_out, val);
      end
      step($urandom_range(0, 4));
      check("rnd_stable_valid", valid, 1'b1);
      check("rnd_stable_data", data_out, val);
      accept("rnd");
    end

    // Both rails of bit 2 -> terminal error.
    link[2][0] = ~link[2][0];
    link[2][1] = ~link[2][1];
    step(SS);
    check("err_early", err, 1'b0);
    step(1);
    check("err_flag", err, 1'b1);
    check("err_bits", err_bits, 4'b0100);
    check("err_valid", valid, 1'b0);
    ready = 1'b1;
    toggle(4'b1011, 4'b1010);
    step(8);
    check("err_frozen_valid", valid, 1'b0);
    check("err_frozen_ack", ack, m_ack);
    check("err_sticky", err, 1'b1);
    check("err_bits_sticky", err_bits, 4'b0100);
    ready = 1'b0;

    do_reset("reset2");
    toggle(4'hF, 4'b1100);
    expect_token("post_reset", 4'b1100);
    accept("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
